// File: rtl/systolic_array_ctrl.sv
// rtl/systolic_array_ctrl.sv - tile sequencer for an output-stationary systolic array
//
// Purpose: accepts one tile command (inner dimension K), strobes the A/B operand
// buffers for K cycles, produces the west/north skew window masks, waits out the
// array drain, pulses array_done, then holds the finished tile until out_ready.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start_valid/ready      tile command handshake, k_len sampled on accept
//   rd_en, rd_addr         operand buffer read strobe and k index (1-cycle read latency)
//   row_mask, col_mask     per-row / per-column edge data-valid windows
//   acc_clear              one-cycle accumulator clear at the first feed cycle
//   array_done             one-cycle pulse to the array's in_done_flag
//   out_valid/out_ready    finished-tile handshake
//   busy                   controller not idle
module systolic_array_ctrl #(
   parameter int ARR_HEIGHT = 4,
   parameter int ARR_WIDTH  = 4,
   parameter int K_BITS     = 10,
   parameter int PE_LATENCY = 2,
   parameter int CNT_BITS   = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [K_BITS-1:0]     k_len,
   output logic                  rd_en,
   output logic [K_BITS-1:0]     rd_addr,
   output logic [ARR_HEIGHT-1:0] row_mask,
   output logic [ARR_WIDTH-1:0]  col_mask,
   output logic                  acc_clear,
   output logic                  array_done,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FEED  = 3'd1,
      S_DRAIN = 3'd2,
      S_FLAG  = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   // Last DRAIN cycle is t = K + H + W - 3 + PE_LATENCY (i.e. N-1).
   localparam logic [CNT_BITS-1:0] DRAIN_LAST_OFS =
      CNT_BITS'(ARR_HEIGHT + ARR_WIDTH - 3 + PE_LATENCY);

   state_t                  state, state_nx;
   logic [CNT_BITS-1:0]     t, t_nx;
   logic [K_BITS-1:0]       k_q, k_nx;
   logic [K_BITS-1:0]       addr_q, addr_nx;
   logic [ARR_HEIGHT-1:0]   row_q, row_nx;
   logic [ARR_WIDTH-1:0]    col_q, col_nx;
   logic [CNT_BITS-1:0]     k_ext, k_nx_ext;
   logic                    feed_last, drain_last, live_nx;

   assign k_ext      = CNT_BITS'(k_q);
   assign k_nx_ext   = CNT_BITS'(k_nx);
   assign feed_last  = (t == k_ext - CNT_BITS'(1));
   assign drain_last = (t == k_ext + DRAIN_LAST_OFS);

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         t      <= '0;
         k_q    <= '0;
         addr_q <= '0;
         row_q  <= '0;
         col_q  <= '0;
      end else begin
         state  <= state_nx;
         t      <= t_nx;
         k_q    <= k_nx;
         addr_q <= addr_nx;
         row_q  <= row_nx;
         col_q  <= col_nx;
      end
   end

   // Next-state and next-register logic
   always_comb begin
      state_nx = state;
      t_nx     = t;
      k_nx     = k_q;
      unique case (state)
         S_IDLE: begin
            t_nx = '0;
            // K=0 commands are dropped without leaving IDLE.
            if (start_valid && (k_len != '0)) begin
               state_nx = S_FEED;
               k_nx     = k_len;
            end
         end
         S_FEED: begin
            t_nx = t + CNT_BITS'(1);
            if (feed_last) state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            t_nx = t + CNT_BITS'(1);
            if (drain_last) state_nx = S_FLAG;
         end
         S_FLAG: begin
            state_nx = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               state_nx = S_IDLE;
               t_nx     = '0;
            end
         end
         default: begin
            state_nx = S_IDLE;
            t_nx     = '0;
         end
      endcase

      // rd_addr tracks t while feeding and freezes at K-1 afterwards.
      addr_nx = (state_nx == S_FEED) ? t_nx[K_BITS-1:0] : addr_q;

      // Masks are computed from next-cycle t so the outputs come straight from flops.
      live_nx = (state_nx == S_FEED) || (state_nx == S_DRAIN);
      row_nx  = '0;
      col_nx  = '0;
      for (int i = 0; i < ARR_HEIGHT; i++) begin
         row_nx[i] = live_nx && (t_nx >= CNT_BITS'(i + 1)) &&
                     (t_nx <= k_nx_ext + CNT_BITS'(i));
      end
      for (int j = 0; j < ARR_WIDTH; j++) begin
         col_nx[j] = live_nx && (t_nx >= CNT_BITS'(j + 1)) &&
                     (t_nx <= k_nx_ext + CNT_BITS'(j));
      end
   end

   // Output logic
   always_comb begin
      start_ready = (state == S_IDLE);
      busy        = (state != S_IDLE);
      rd_en       = (state == S_FEED);
      acc_clear   = (state == S_FEED) && (t == '0);
      array_done  = (state == S_FLAG);
      out_valid   = (state == S_OUT);
      rd_addr     = addr_q;
      row_mask    = row_q;
      col_mask    = col_q;
   end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// tb/tb_systolic_array_ctrl.sv - directed table-driven bench for systolic_array_ctrl
module tb_systolic_array_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_valid;
   logic       start_ready;
   logic [9:0] k_len;
   logic       rd_en;
   logic [9:0] rd_addr;
   logic [3:0] row_mask;
   logic [3:0] col_mask;
   logic       acc_clear;
   logic       array_done;
   logic       out_valid;
   logic       out_ready;
   logic       busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   systolic_array_ctrl #(
      .ARR_HEIGHT(4), .ARR_WIDTH(4), .K_BITS(10), .PE_LATENCY(2), .CNT_BITS(12)
   ) dut (
      .clk(clk), .reset(reset),
      .start_valid(start_valid), .start_ready(start_ready), .k_len(k_len),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .row_mask(row_mask), .col_mask(col_mask),
      .acc_clear(acc_clear), .array_done(array_done),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   typedef struct {
      logic       sv;
      logic [9:0] k;
      logic       ordy;
      logic       e_sr;
      logic       e_busy;
      logic       e_rd;
      logic       chk_addr;
      logic [9:0] e_addr;
      logic       e_ac;
      logic [3:0] e_row;
      logic [3:0] e_col;
      logic       e_done;
      logic       e_ov;
   } vec_t;

   vec_t tbl[26];

   // Hand-computed window for K=8, H=W=4: bit i set for i+1 <= t <= 8+i.
   function automatic logic [3:0] win8(input int t);
      case (t)
         1:             return 4'b0001;
         2:             return 4'b0011;
         3:             return 4'b0111;
         4, 5, 6, 7, 8: return 4'b1111;
         9:             return 4'b1110;
         10:            return 4'b1100;
         11:            return 4'b1000;
         default:       return 4'b0000;
      endcase
   endfunction

   task automatic set_row(input int r, input logic sv, input logic [9:0] k, input logic ordy,
                          input logic sr, input logic bz, input logic rd, input logic ca,
                          input logic [9:0] addr, input logic ac, input logic [3:0] m,
                          input logic dn, input logic ov);
      tbl[r].sv = sv;       tbl[r].k = k;         tbl[r].ordy = ordy;
      tbl[r].e_sr = sr;     tbl[r].e_busy = bz;   tbl[r].e_rd = rd;
      tbl[r].chk_addr = ca; tbl[r].e_addr = addr; tbl[r].e_ac = ac;
      tbl[r].e_row = m;     tbl[r].e_col = m;     tbl[r].e_done = dn;
      tbl[r].e_ov = ov;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   logic [13:0] act_v, exp_v;
   int first_done, n_done;

   initial begin
      reset = 1'b1; start_valid = 1'b0; k_len = '0; out_ready = 1'b0;

      // Row 0 accepts K=8. Rows 1..8 are FEED (t=0..7), rows 9..16 DRAIN (t=8..15),
      // row 17 FLAG, rows 18..23 OUT. start_valid with k=3 stays high throughout the
      // busy period and out_ready is high during FEED/DRAIN/FLAG; both must be ignored.
      set_row(0, 1, 10'd8, 0, 1, 0, 0, 1, 10'd0, 0, 4'b0, 0, 0);
      for (int r = 1; r <= 8; r++)
         set_row(r, 1, 10'd3, 1, 0, 1, 1, 1, 10'(r - 1), (r == 1), win8(r - 1), 0, 0);
      for (int r = 9; r <= 16; r++)
         set_row(r, 1, 10'd3, 1, 0, 1, 0, 1, 10'd7, 0, win8(r - 1), 0, 0);
      set_row(17, 1, 10'd3, 1, 0, 1, 0, 0, 10'd0, 0, 4'b0, 1, 0);
      for (int r = 18; r <= 22; r++)
         set_row(r, 1, 10'd3, 0, 0, 1, 0, 0, 10'd0, 0, 4'b0, 0, 1);
      set_row(23, 1, 10'd3, 1, 0, 1, 0, 0, 10'd0, 0, 4'b0, 0, 1);
      set_row(24, 0, 10'd3, 0, 1, 0, 0, 0, 10'd0, 0, 4'b0, 0, 0);
      set_row(25, 0, 10'd0, 0, 1, 0, 0, 0, 10'd0, 0, 4'b0, 0, 0);

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_state",
            {start_ready, busy, rd_en, acc_clear, array_done, out_valid, row_mask, col_mask},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0});
      check("reset_rd_addr", rd_addr, 10'd0);
      @(posedge clk); #1;

      // Table run: K=8 tile
      for (int r = 0; r < 26; r++) begin
         start_valid = tbl[r].sv;
         k_len       = tbl[r].k;
         out_ready   = tbl[r].ordy;
         @(negedge clk);
         act_v = {start_ready, busy, rd_en, acc_clear, array_done, out_valid, row_mask, col_mask};
         exp_v = {tbl[r].e_sr, tbl[r].e_busy, tbl[r].e_rd, tbl[r].e_ac, tbl[r].e_done,
                  tbl[r].e_ov, tbl[r].e_row, tbl[r].e_col};
         check($sformatf("row%0d_ctl", r), 32'(act_v), 32'(exp_v));
         if (tbl[r].chk_addr) check($sformatf("row%0d_addr", r), 32'(rd_addr), 32'(tbl[r].e_addr));
         @(posedge clk); #1;
      end

      // k_len=0 is ignored
      start_valid = 1'b1; k_len = 10'd0; out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("k0_cyc%0d", c), {27'd0, start_ready, busy, rd_en, acc_clear, array_done},
               {27'd0, 5'b10000});
         @(posedge clk); #1;
      end

      // Reset at t=5 of a K=8 tile
      start_valid = 1'b1; k_len = 10'd8;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("pre_reset_addr_t5", 32'(rd_addr), 32'd5);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("mid_reset_idle",
            {20'd0, start_ready, busy, rd_en, out_valid, row_mask, col_mask},
            {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0});
      @(posedge clk); #1;

      // K=1 tile after reset: array_done expected at accept+10
      start_valid = 1'b1; k_len = 10'd1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      first_done = -1; n_done = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (cyc == 1) check("k1_feed_rd_ac", {30'd0, rd_en, acc_clear}, 32'd3);
         if (cyc == 2) check("k1_drain_no_rd", {31'd0, rd_en}, 32'd0);
         if (array_done) begin
            n_done++;
            if (first_done < 0) first_done = cyc;
         end
         @(posedge clk); #1;
      end
      check("k1_done_cycle", 32'(first_done), 32'd10);
      check("k1_done_count", 32'(n_done), 32'd1);
      check("k1_out_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("k1_back_idle", {30'd0, start_ready, out_valid}, 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
